period_meter: RTL and testbench

//   Measures a slow square wave, such as the divided clock from our ripple-divider blocks, in units of in_clk.

---
 rtl/period_meter.sv | 209 ++++++++++++++++++++
 tb/tb_period_meter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//   Measures a slow square wave (for example a ripple-divider output) in units
//   of in_clk. sig_in is synchronised into the in_clk domain, its rising edges
//   are detected, and every full period between two successive rising edges
//   is reported as a period count plus the number of cycles the synchronised
//   signal was high in that period. Results are offered to a consumer over a
//   valid/ready handshake.
//
// Ports
//   in_clk      in   1      system clock, all logic on posedge
//   reset       in   1      synchronous, active-high reset
//   sig_in      in   1      asynchronous slow signal to measure
//   meas_ready  in   1      consumer accepts the result this cycle
//   meas_valid  out  1      period/high_count/overflow hold a result
//   period      out  WIDTH  in_clk cycles between two successive rising edges
//   high_count  out  WIDTH  in_clk cycles the signal was high in that period
//   overflow    out  1      result saturated (true period > 2^WIDTH-1)
//   missed      out  1      sticky: an unaccepted result was overwritten
//
// Parameters
//   WIDTH        counter width; the largest reportable count is 2^WIDTH-1
//   SYNC_STAGES  flop stages in the sig_in synchroniser (2..4)
// -----------------------------------------------------------------------------
module period_meter #(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_count,
  output logic             overflow,
  output logic             missed
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ARM  = 1'b0,
    MEAS = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sig_s;
  logic                   sig_s_d_reg;
  logic                   rise_reg;

  assign sig_s = sync_reg[SYNC_STAGES-1];

  // The edge flag is registered so the FSM sees a clean one-cycle pulse
  // SYNC_STAGES+1 cycles after the sig_in edge. Because every edge is delayed
  // by the same amount, period and high counts are unaffected by the lag.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      sync_reg    <= '0;
      sig_s_d_reg <= 1'b0;
      rise_reg    <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      sig_s_d_reg <= sig_s;
      rise_reg    <= sig_s & ~sig_s_d_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement state
  // ---------------------------------------------------------------------------
  state_t           state_reg,   state_next;
  logic [WIDTH-1:0] cnt_reg,     cnt_next;
  logic [WIDTH-1:0] hcnt_reg,    hcnt_next;
  logic             sat_reg,     sat_next;

  logic [WIDTH-1:0] period_reg,  period_next;
  logic [WIDTH-1:0] high_reg,    high_next;
  logic             ovf_reg,     ovf_next;
  logic             valid_reg,   valid_next;
  logic             missed_reg,  missed_next;

  logic             new_result;
  logic             transfer;
  logic             cnt_at_max;
  logic             hcnt_at_max;
  logic [WIDTH-1:0] sig_s_ext;

  assign cnt_at_max  = (cnt_reg == CNT_MAX);
  assign hcnt_at_max = (hcnt_reg == CNT_MAX);
  assign sig_s_ext   = {{(WIDTH-1){1'b0}}, sig_s};
  assign transfer    = valid_reg & meas_ready;

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_reg <= ARM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      hcnt_reg   <= '0;
      sat_reg    <= 1'b0;
      period_reg <= '0;
      high_reg   <= '0;
      ovf_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      missed_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      hcnt_reg   <= hcnt_next;
      sat_reg    <= sat_next;
      period_reg <= period_next;
      high_reg   <= high_next;
      ovf_reg    <= ovf_next;
      valid_reg  <= valid_next;
      missed_reg <= missed_next;
    end
  end

  // Next-state, counters and result capture.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hcnt_next   = hcnt_reg;
    sat_next    = sat_reg;
    period_next = period_reg;
    high_next   = high_reg;
    ovf_next    = ovf_reg;
    new_result  = 1'b0;

    unique case (state_reg)
      ARM: begin
        // The first rise after reset only opens the first measurement window.
        if (rise_reg) begin
          state_next = MEAS;
          cnt_next   = CNT_ONE;
          hcnt_next  = sig_s_ext;
          sat_next   = 1'b0;
        end
      end

      MEAS: begin
        if (rise_reg) begin
          // Close the current window and open the next in the same cycle,
          // so consecutive periods are measured back to back.
          new_result  = 1'b1;
          period_next = cnt_reg;
          high_next   = hcnt_reg;
          ovf_next    = sat_reg;
          cnt_next    = CNT_ONE;
          hcnt_next   = sig_s_ext;
          sat_next    = 1'b0;
        end else begin
          // A count of exactly all-ones is still a valid period; only an
          // attempt to count past it marks the window as saturated.
          if (cnt_at_max) begin
            sat_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
          if (sig_s) begin
            if (hcnt_at_max) begin
              sat_next = 1'b1;
            end else begin
              hcnt_next = hcnt_reg + CNT_ONE;
            end
          end
        end
      end

      default: begin
        state_next = ARM;
      end
    endcase
  end

  // Output handshake. A new result always wins over a transfer in the same
  // cycle, so valid stays high. missed travels with the data it qualifies:
  // it is set when pending data is overwritten and cleared by the transfer
  // that hands the surviving result to the consumer.
  always_comb begin
    valid_next  = valid_reg;
    missed_next = missed_reg;
    if (new_result) begin
      valid_next = 1'b1;
      if (valid_reg && !meas_ready) begin
        missed_next = 1'b1;
      end
    end else if (transfer) begin
      valid_next  = 1'b0;
      missed_next = 1'b0;
    end
  end

  assign meas_valid = valid_reg;
  assign period     = period_reg;
  assign high_count = high_reg;
  assign overflow   = ovf_reg;
  assign missed     = missed_reg;

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//   Directed bench for period_meter (WIDTH=8 so saturation is reachable).
//   A reference model derives expected results from the sampled sig_in
//   history (rise-to-rise distance, count of high samples) and the handshake
//   rules; a compare process checks every DUT output on every negedge.
//   Directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_period_meter;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int MAXV = (1 << W) - 1;
  localparam int HN   = 16384;

  logic         clk = 1'b0;
  logic         reset;
  logic         sig_in;
  logic         meas_ready;
  logic         meas_valid;
  logic [W-1:0] period;
  logic [W-1:0] high_count;
  logic         overflow;
  logic         missed;

  period_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .in_clk     (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .period     (period),
    .high_count (high_count),
    .overflow   (overflow),
    .missed     (missed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int     due;
    int     per;
    int     high;
    bit     ovf;
  } res_t;

  res_t         pq[$];
  bit           hist [0:HN-1];
  bit           last_s;
  bit           armed;
  int           r0;
  bit           m_valid;
  bit           m_missed;
  bit           m_ovf;
  logic [W-1:0] m_per;
  logic [W-1:0] m_high;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc >= HN - 1) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HN - 1);
      $fatal(1);
    end
    hist[cyc] = sig_in;
    if (reset) begin
      m_valid  = 1'b0;
      m_missed = 1'b0;
      m_ovf    = 1'b0;
      m_per    = '0;
      m_high   = '0;
      last_s   = 1'b0;
      armed    = 1'b0;
      pq.delete();
    end else begin
      bit new_r;
      bit xfer;
      new_r = (pq.size() > 0) && (pq[0].due == cyc);
      xfer  = m_valid && meas_ready;
      if (new_r) begin
        if (m_valid && !meas_ready) m_missed = 1'b1;
        m_valid = 1'b1;
        m_per   = W'(pq[0].per);
        m_high  = W'(pq[0].high);
        m_ovf   = pq[0].ovf;
        void'(pq.pop_front());
      end else if (xfer) begin
        m_valid  = 1'b0;
        m_missed = 1'b0;
      end
      // A rise of the sampled input closes a period; its result appears
      // after the synchroniser, the edge flag and the result register.
      if (sig_in && !last_s) begin
        if (armed) begin
          res_t r;
          int   p;
          int   h;
          p = cyc - r0;
          h = 0;
          for (int j = r0; j < cyc; j++) h += int'(hist[j]);
          r.due  = cyc + S + 1;
          r.ovf  = (p > MAXV);
          r.per  = (p > MAXV) ? MAXV : p;
          r.high = (h > MAXV) ? MAXV : h;
          pq.push_back(r);
        end
        armed = 1'b1;
        r0    = cyc;
      end
      last_s = sig_in;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      logic [2*W+2:0] act;
      logic [2*W+2:0] exp;
      act = {meas_valid, missed, overflow, period, high_count};
      exp = {m_valid, m_missed, m_ovf, m_per, m_high};
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL model_cmp cycle %0d: got v=%b m=%b o=%b p=%0d h=%0d expected v=%b m=%b o=%b p=%0d h=%0d",
                    cyc, meas_valid, missed, overflow, period, high_count,
                    m_valid, m_missed, m_ovf, m_per, m_high);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drive(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) step();
    sig_in = 1'b0;
    repeat (lo) step();
  endtask

  // Drive one period and, shortly after its opening rise, check the result
  // of the period that rise just closed.
  task automatic pcheck(input int hi, input int lo, input int ep, input int eh, input bit eo);
    sig_in = 1'b1;
    repeat (5) step();
    chk("period", 32'(period), 32'(ep));
    chk("high_count", 32'(high_count), 32'(eh));
    chk("overflow", 32'(overflow), 32'(eo));
    repeat (hi - 5) step();
    sig_in = 1'b0;
    repeat (lo) step();
  endtask

  initial begin
    int c;
    int lat;

    reset      = 1'b1;
    sig_in     = 1'b0;
    meas_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_high", 32'(high_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_missed", 32'(missed), 32'd0);

    // 100-cycle period, 40 high.
    drive(40, 60);
    chk("arm_no_result", 32'(period), 32'd0);
    repeat (4) pcheck(40, 60, 100, 40, 1'b0);

    // 16-cycle divider output; latency of the first result.
    do_reset();
    drive(8, 8);
    sig_in = 1'b1;
    c   = cyc;
    lat = -1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) sig_in = 1'b0;
      step();
      if (meas_valid && lat < 0) lat = cyc - c;
    end
    chk("first_latency", 32'(lat), 32'(S + 2));
    chk("p16_first", 32'(period), 32'd16);
    repeat (3) pcheck(8, 8, 16, 8, 1'b0);

    // Saturation: 300-cycle period, then 200.
    drive(150, 150);
    pcheck(100, 100, 255, 150, 1'b1);
    pcheck(100, 100, 200, 100, 1'b0);

    // Consumer stalls across three 50-cycle periods, then one-cycle pulse.
    meas_ready = 1'b0;
    repeat (3) drive(25, 25);
    sig_in = 1'b1;
    repeat (5) step();
    chk("stall_valid", 32'(meas_valid), 32'd1);
    chk("stall_missed", 32'(missed), 32'd1);
    chk("stall_period", 32'(period), 32'd50);
    meas_ready = 1'b1;
    step();
    meas_ready = 1'b0;
    chk("pulse_drop_valid", 32'(meas_valid), 32'd0);
    repeat (19) step();
    sig_in = 1'b0;
    repeat (25) step();
    meas_ready = 1'b1;
    pcheck(25, 25, 50, 25, 1'b0);
    chk("clean_xfer_missed", 32'(missed), 32'd0);

    // New result in the same cycle as a transfer.
    meas_ready = 1'b0;
    drive(25, 25);
    sig_in = 1'b1;
    repeat (3) step();
    meas_ready = 1'b1;
    step();
    chk("load_xfer_valid", 32'(meas_valid), 32'd1);
    chk("load_xfer_missed", 32'(missed), 32'd0);
    step();
    chk("after_xfer_valid", 32'(meas_valid), 32'd0);
    repeat (20) step();
    sig_in = 1'b0;
    repeat (25) step();

    // Reset 30 cycles into a 100-cycle period.
    drive(25, 75);
    drive(25, 75);
    sig_in = 1'b1;
    repeat (25) step();
    sig_in = 1'b0;
    repeat (5) step();
    do_reset();
    chk("mid_rst_valid", 32'(meas_valid), 32'd0);
    chk("mid_rst_period", 32'(period), 32'd0);
    chk("mid_rst_high", 32'(high_count), 32'd0);
    repeat (69) step();
    drive(25, 75);
    chk("rearm_valid", 32'(meas_valid), 32'd0);
    chk("rearm_period", 32'(period), 32'd0);
    pcheck(25, 75, 100, 25, 1'b0);

    // Long low phase past the counter range, then 20-cycle periods.
    drive(10, MAXV + 1 + 10);
    pcheck(10, 10, MAXV, 10, 1'b1);
    pcheck(10, 10, 20, 10, 1'b0);
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
